// File: rtl/floppy_track_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : apple2_disk_pkg
//  Description : Shared geometry constants, FSM state encoding and the
//                track-to-LBA helper for the Disk II track buffer controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package apple2_disk_pkg;

  // 512-byte SD blocks per 6656-byte NIB track
  localparam int SECTORS_PER_TRACK = 13;
  // Number of tracks that exist on an image
  localparam int NUM_TRACKS        = 35;
  // Width of the head track number
  localparam int TRACK_W           = 6;
  // Width of the sector index (must hold SECTORS_PER_TRACK itself)
  localparam int SEC_W             = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } disk_state_e;

  // First SD block of a track; 6-bit track times a small constant cannot overflow 32 bits
  function automatic logic [31:0] track_lba(input logic [TRACK_W-1:0] trk, input int sectors);
    return 32'(trk) * 32'(sectors);
  endfunction

endpackage
`default_nettype wire

// File: rtl/floppy_track_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Interface   : floppy_track_ctrl_if
//  Description : Bundles the Apple II core track-buffer signals and the
//                hps_io SD block handshake seen by the track controller.
//                master = controller side, slave = core / hps_io side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface floppy_track_ctrl_if;

  // Core side
  logic [apple2_disk_pkg::TRACK_W-1:0] track;
  logic                                track_we;
  logic [apple2_disk_pkg::SEC_W-1:0]   track_sec;
  logic                                cpu_wait;
  logic                                busy;

  // Image status from hps_io
  logic                                img_mounted;
  logic                                img_present;
  logic                                img_readonly;

  // SD block handshake
  logic [31:0]                         sd_lba;
  logic                                sd_rd;
  logic                                sd_wr;
  logic                                sd_ack;

  modport master (
    input  track, track_we, img_mounted, img_present, img_readonly, sd_ack,
    output sd_lba, sd_rd, sd_wr, track_sec, cpu_wait, busy
  );

  modport slave (
    output track, track_we, img_mounted, img_present, img_readonly, sd_ack,
    input  sd_lba, sd_rd, sd_wr, track_sec, cpu_wait, busy
  );

endinterface
`default_nettype wire

// File: rtl/floppy_track_ctrl_sd_block_seq.sv
`default_nettype none
// ============================================================================
//  Module      : sd_block_seq
//  Description : Runs one track's worth of SD block transfers in either
//                direction. Tracks sd_ack edges against a registered copy,
//                advances the LBA on each ack rise, the sector index on each
//                ack fall, and drops the request on the last block's ack rise.
//  Revision    : 1.0 - initial release
// ============================================================================
module sd_block_seq
  import apple2_disk_pkg::*;
#(
  parameter int SECTORS = SECTORS_PER_TRACK
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_start,
  input  wire logic              i_start_wr,
  input  wire logic [31:0]       i_start_lba,
  input  wire logic              i_sd_ack,
  output logic [31:0]            o_sd_lba,
  output logic                   o_sd_rd,
  output logic                   o_sd_wr,
  output logic [SEC_W-1:0]       o_track_sec,
  output logic                   o_last_fall
);

  localparam logic [SEC_W-1:0] c_last_sec = SEC_W'(SECTORS - 1);
  localparam logic [SEC_W-1:0] c_sec_one  = SEC_W'(1);

  logic              r_ack;
  logic              r_active;
  logic [31:0]       r_lba;
  logic              r_rd;
  logic              r_wr;
  logic [SEC_W-1:0]  r_sec;

  logic              w_ack_rise;
  logic              w_ack_fall;
  logic              w_last_sec;

  assign w_ack_rise  = i_sd_ack & ~r_ack;
  assign w_ack_fall  = ~i_sd_ack & r_ack;
  assign w_last_sec  = (r_sec == c_last_sec);
  // The final block's ack falling ends the burst; the parent reacts on the same edge
  assign o_last_fall = r_active & w_ack_fall & w_last_sec;

  // Ack edge history, request levels, block address and sector index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack    <= 1'b0;
      r_active <= 1'b0;
      r_lba    <= 32'd0;
      r_rd     <= 1'b0;
      r_wr     <= 1'b0;
      r_sec    <= '0;
    end else begin
      r_ack <= i_sd_ack;
      if (i_start) begin
        // A new burst overrides whatever the previous one was finishing
        r_active <= 1'b1;
        r_lba    <= i_start_lba;
        r_rd     <= ~i_start_wr;
        r_wr     <= i_start_wr;
        r_sec    <= '0;
      end else if (r_active) begin
        if (w_ack_rise && (r_rd || r_wr)) begin
          r_lba <= r_lba + 32'd1;
          if (w_last_sec) begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
          end
        end
        if (w_ack_fall) begin
          r_sec <= r_sec + c_sec_one;
          if (w_last_sec) begin
            r_active <= 1'b0;
          end
        end
      end
    end
  end

  assign o_sd_lba    = r_lba;
  assign o_sd_rd     = r_rd;
  assign o_sd_wr     = r_wr;
  assign o_track_sec = r_sec;

endmodule
`default_nettype wire

// File: rtl/floppy_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : floppy_track_ctrl
//  Description : Disk II track buffer sequencer. Writes a dirty track back to
//                the SD image, then loads the newly selected track, holding
//                the CPU in wait while the buffer is being exchanged. Image
//                mounts invalidate the buffer and force a fresh load.
//  Revision    : 1.0 - initial release
// ============================================================================
module floppy_track_ctrl
  import apple2_disk_pkg::*;
#(
  parameter int SECTORS = SECTORS_PER_TRACK,
  parameter int TRACKS  = NUM_TRACKS
) (
  input  wire logic           clk_sys,
  input  wire logic           reset_n,
  floppy_track_ctrl_if.master bus
);

  // One extra bit so TRACKS up to 64 still compares correctly
  localparam logic [TRACK_W:0] c_tracks = TRACKS[TRACK_W:0];

  disk_state_e         r_state;
  disk_state_e         w_state_nxt;

  logic [TRACK_W-1:0]  r_cur_track;
  logic [TRACK_W-1:0]  r_target;
  logic                r_loaded;
  logic                r_dirty;
  logic                r_remount;
  logic                r_mnt;
  logic                r_cpu_wait;
  logic                r_busy;

  logic [TRACK_W-1:0]  w_cur_nxt;
  logic [TRACK_W-1:0]  w_target_nxt;
  logic                w_loaded_nxt;
  logic                w_dirty_nxt;
  logic                w_remount_nxt;
  logic                w_busy_nxt;

  logic                w_mnt_rise;
  logic                w_remount;
  logic                w_consume;
  logic                w_start;
  logic                w_start_wr;
  logic [TRACK_W-1:0]  w_start_trk;
  logic                w_last_fall;
  logic                w_track_valid;
  logic                w_track_moved;

  // A mount edge in the current cycle already counts, so a simultaneous
  // track change cannot sneak a write-back of the discarded buffer in first
  assign w_mnt_rise    = bus.img_mounted & ~r_mnt;
  assign w_remount     = r_remount | w_mnt_rise;
  assign w_track_valid = ({1'b0, bus.track} < c_tracks);
  assign w_track_moved = (bus.track != r_cur_track);

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decision and burst launch
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_start_wr  = 1'b0;
    w_start_trk = bus.track;
    w_consume   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Never raise a request while hps_io is still acknowledging
        if (!bus.sd_ack) begin
          if (w_remount) begin
            w_consume = 1'b1;
            if (bus.img_present) begin
              w_state_nxt = ST_READ;
              w_start     = 1'b1;
            end
          end else if (r_loaded && w_track_moved && r_dirty) begin
            w_state_nxt = ST_WRITE;
            w_start     = 1'b1;
            w_start_wr  = 1'b1;
            w_start_trk = r_cur_track;
          end else if ((!r_loaded || w_track_moved) && bus.img_present && w_track_valid) begin
            w_state_nxt = ST_READ;
            w_start     = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        if (w_last_fall) begin
          w_state_nxt = ST_READ;
          w_start     = 1'b1;
          w_start_trk = r_target;
        end
      end
      ST_READ: begin
        if (w_last_fall) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Next values of buffer bookkeeping and the registered status outputs
  always_comb begin
    w_busy_nxt    = (w_state_nxt != ST_IDLE);
    w_target_nxt  = r_target;
    w_cur_nxt     = r_cur_track;
    w_loaded_nxt  = r_loaded;
    w_dirty_nxt   = r_dirty;
    w_remount_nxt = w_consume ? 1'b0 : w_remount;

    if (r_state == ST_IDLE && w_start) begin
      w_target_nxt = bus.track;
    end
    if (r_state == ST_IDLE && bus.track_we && r_loaded && !bus.img_readonly) begin
      w_dirty_nxt = 1'b1;
    end
    if (w_consume) begin
      w_dirty_nxt  = 1'b0;
      w_loaded_nxt = 1'b0;
    end
    if (r_state == ST_WRITE && w_last_fall) begin
      w_dirty_nxt = 1'b0;
    end
    if (r_state == ST_READ && w_last_fall) begin
      w_cur_nxt    = r_target;
      w_loaded_nxt = 1'b1;
    end
  end

  // Bookkeeping and status registers
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_cur_track <= '0;
      r_target    <= '0;
      r_loaded    <= 1'b0;
      r_dirty     <= 1'b0;
      r_remount   <= 1'b0;
      r_mnt       <= 1'b0;
      r_cpu_wait  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cur_track <= w_cur_nxt;
      r_target    <= w_target_nxt;
      r_loaded    <= w_loaded_nxt;
      r_dirty     <= w_dirty_nxt;
      r_remount   <= w_remount_nxt;
      r_mnt       <= bus.img_mounted;
      r_cpu_wait  <= w_busy_nxt;
      r_busy      <= w_busy_nxt;
    end
  end

  sd_block_seq #(
    .SECTORS (SECTORS)
  ) u_seq (
    .clk         (clk_sys),
    .rst_n       (reset_n),
    .i_start     (w_start),
    .i_start_wr  (w_start_wr),
    .i_start_lba (track_lba(w_start_trk, SECTORS)),
    .i_sd_ack    (bus.sd_ack),
    .o_sd_lba    (bus.sd_lba),
    .o_sd_rd     (bus.sd_rd),
    .o_sd_wr     (bus.sd_wr),
    .o_track_sec (bus.track_sec),
    .o_last_fall (w_last_fall)
  );

  assign bus.cpu_wait = r_cpu_wait;
  assign bus.busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_floppy_track_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_floppy_track_ctrl
//  Description : Directed and randomised bench for floppy_track_ctrl. The
//                expected transfers come from a transaction-level model of
//                the buffer (current track, loaded, dirty).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_floppy_track_ctrl;

  localparam int SECT = 13;
  localparam int TRKS = 35;

  logic clk_sys;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  // Buffer model
  int unsigned m_cur;
  bit          m_loaded;
  bit          m_dirty;
  bit          m_ro;

  floppy_track_ctrl_if bus ();

  floppy_track_ctrl #(
    .SECTORS (SECT),
    .TRACKS  (TRKS)
  ) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.sd_rd || bus.sd_wr) begin
        got = 1'b1;
        break;
      end
      @(negedge clk_sys);
    end
  endtask

  // One full track burst as hps_io would acknowledge it
  task automatic xfer(input bit wr, input int unsigned base, input bit chained,
                      input int mount_blk, input int reset_blk);
    bit got;
    int gap;
    wait_req(got);
    chk("req_rise", 32'(got), 32'd1);
    chk("sd_wr_dir", 32'(bus.sd_wr), 32'(wr));
    chk("sd_rd_dir", 32'(bus.sd_rd), 32'(!wr));
    chk("lba_start", bus.sd_lba, base);
    chk("sec_start", 32'(bus.track_sec), 32'd0);
    chk("wait_start", 32'(bus.cpu_wait), 32'd1);
    chk("busy_start", 32'(bus.busy), 32'd1);
    for (int k = 0; k < SECT; k++) begin
      bus.sd_ack = 1'b1;
      if (k == mount_blk) bus.img_mounted = 1'b1;
      @(negedge clk_sys);
      chk("lba_inc", bus.sd_lba, base + 32'(k) + 32'd1);
      chk("req_hold", 32'(bus.sd_rd | bus.sd_wr), 32'(k != SECT - 1));
      if (k == reset_blk) begin
        reset_n = 1'b0;
        #1;
        chk("rst_rd", 32'(bus.sd_rd), 32'd0);
        chk("rst_wait", 32'(bus.cpu_wait), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk("no_req_ack_high", 32'(bus.sd_rd | bus.sd_wr), 32'd0);
        bus.sd_ack = 1'b0;
        return;
      end
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge clk_sys);
      chk("req_hold2", 32'(bus.sd_rd | bus.sd_wr), 32'(k != SECT - 1));
      bus.sd_ack = 1'b0;
      @(negedge clk_sys);
      chk("sec_inc", 32'(bus.track_sec), (chained && k == SECT - 1) ? 32'd0 : 32'(k + 1));
      chk("wait_blk", 32'(bus.cpu_wait), (k == SECT - 1 && !chained) ? 32'd0 : 32'd1);
      gap = $urandom_range(0, 2);
      if (k != SECT - 1) repeat (gap) @(negedge clk_sys);
    end
  endtask

  // Move the head and expect whatever buffer exchange the model calls for
  task automatic move_to(input int unsigned trk);
    bus.track = 6'(trk);
    if (m_loaded && trk != m_cur && m_dirty) begin
      xfer(1'b1, m_cur * SECT, 1'b1, -1, -1);
      xfer(1'b0, trk * SECT, 1'b0, -1, -1);
      m_dirty  = 1'b0;
      m_cur    = trk;
      m_loaded = 1'b1;
    end else if ((!m_loaded || trk != m_cur) && trk < TRKS) begin
      xfer(1'b0, trk * SECT, 1'b0, -1, -1);
      m_cur    = trk;
      m_loaded = 1'b1;
    end else begin
      repeat (4) @(negedge clk_sys);
      chk("no_req", 32'(bus.sd_rd | bus.sd_wr), 32'd0);
      chk("idle_wait", 32'(bus.cpu_wait), 32'd0);
    end
  endtask

  task automatic pulse_we();
    bus.track_we = 1'b1;
    @(negedge clk_sys);
    bus.track_we = 1'b0;
    if (m_loaded && !m_ro) m_dirty = 1'b1;
  endtask

  initial begin
    int unsigned op;
    int unsigned trk;
    n_tests          = 0;
    n_fail           = 0;
    m_cur            = 0;
    m_loaded         = 1'b0;
    m_dirty          = 1'b0;
    m_ro             = 1'b0;
    reset_n          = 1'b0;
    bus.track        = 6'd0;
    bus.track_we     = 1'b0;
    bus.img_mounted  = 1'b0;
    bus.img_present  = 1'b0;
    bus.img_readonly = 1'b0;
    bus.sd_ack       = 1'b0;

    // Reset values
    repeat (2) @(negedge clk_sys);
    chk("rst_lba", bus.sd_lba, 32'd0);
    chk("rst_sd_rd", 32'(bus.sd_rd), 32'd0);
    chk("rst_sd_wr", 32'(bus.sd_wr), 32'd0);
    chk("rst_sec", 32'(bus.track_sec), 32'd0);
    chk("rst_cpu_wait", 32'(bus.cpu_wait), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;

    // No image: nothing to load
    repeat (4) @(negedge clk_sys);
    chk("no_image_idle", 32'(bus.sd_rd | bus.sd_wr), 32'd0);

    // Mount an image on track 0
    bus.img_present = 1'b1;
    bus.img_mounted = 1'b1;
    @(negedge clk_sys);
    chk("mount_latency", 32'(bus.sd_rd), 32'd1);
    xfer(1'b0, 0, 1'b0, -1, -1);
    chk("load0_lba_end", bus.sd_lba, 32'd13);
    chk("load0_sec_end", 32'(bus.track_sec), 32'd13);
    bus.img_mounted = 1'b0;
    m_cur = 0; m_loaded = 1'b1;

    // Step to track 5
    bus.track = 6'd5;
    @(negedge clk_sys);
    chk("step_latency", 32'(bus.sd_rd), 32'd1);
    xfer(1'b0, 65, 1'b0, -1, -1);
    m_cur = 5;

    // Dirty write-back of track 3 then load of track 4
    move_to(3);
    pulse_we();
    move_to(4);

    // Same with a read-only image: no write-back
    bus.img_readonly = 1'b1; m_ro = 1'b1;
    move_to(3);
    pulse_we();
    move_to(4);
    bus.img_readonly = 1'b0; m_ro = 1'b0;

    // Mount and track change in the same cycle with a dirty buffer: read only
    pulse_we();
    bus.track       = 6'd9;
    bus.img_mounted = 1'b1;
    xfer(1'b0, 9 * SECT, 1'b0, -1, -1);
    bus.img_mounted = 1'b0;
    m_cur = 9; m_loaded = 1'b1; m_dirty = 1'b0;

    // Mount during the 5th block of a read: finish, then reload current track
    pulse_we();
    bus.track = 6'd10;
    xfer(1'b1, 9 * SECT, 1'b1, -1, -1);
    xfer(1'b0, 10 * SECT, 1'b0, 4, -1);
    bus.img_mounted = 1'b0;
    m_cur = 10; m_loaded = 1'b0; m_dirty = 1'b0;
    move_to(10);

    // Reset during the 7th block; buffer is invalid afterwards
    bus.track = 6'd12;
    xfer(1'b0, 12 * SECT, 1'b0, -1, 6);
    m_loaded = 1'b0; m_dirty = 1'b0; m_cur = 0;
    move_to(12);

    // Randomised head moves, buffer writes and read-only toggles
    for (int it = 0; it < 24; it++) begin
      op = $urandom_range(0, 4);
      if (op == 0) begin
        pulse_we();
      end else if (op == 1) begin
        m_ro = ($urandom_range(0, 2) == 0);
        bus.img_readonly = m_ro;
        @(negedge clk_sys);
      end else begin
        trk = m_dirty ? $urandom_range(0, TRKS - 1) : $urandom_range(0, TRKS + 4);
        move_to(trk);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
